// File: rtl/vector_mac_pkg.sv
// Shared defaults and FSM encoding for the vector multiply-accumulate block.
package vector_mac_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefMaxWidth  = 9;
    localparam int unsigned DefAccWidth  = 32;
    localparam int unsigned CountWidth   = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } mac_state_e;

endpackage

// File: rtl/vector_mac_dot_tree.sv
// Two-stage dot product: registered element products, then registered sign-extended sum.
module dot_tree
    import vector_mac_pkg::*;
#(
    parameter int unsigned DataWidth = DefDataWidth,
    parameter int unsigned MaxWidth  = DefMaxWidth,
    parameter int unsigned AccWidth  = DefAccWidth
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          valid_i,
    input  logic [MaxWidth*DataWidth-1:0] vec_i,
    input  logic [MaxWidth*DataWidth-1:0] weights_i,
    output logic                          prod_valid_o,
    output logic                          sum_valid_o,
    output logic [AccWidth-1:0]           sum_o
);

    localparam int unsigned ProdWidth = 2 * DataWidth;

    logic signed [ProdWidth-1:0] prod_d [MaxWidth];
    logic signed [ProdWidth-1:0] prod_q [MaxWidth];
    logic        [DataWidth-1:0] elem_a, elem_b;
    logic signed [ProdWidth-1:0] ext_a, ext_b;
    logic        [AccWidth-1:0]  sum_d, sum_q;
    logic                        prod_valid_q, sum_valid_q;

    // Operands are widened first so the product is computed at full 2*DataWidth precision.
    always_comb begin
        elem_a = '0;
        elem_b = '0;
        ext_a  = '0;
        ext_b  = '0;
        for (int i = 0; i < int'(MaxWidth); i++) begin
            elem_a    = vec_i[i*DataWidth +: DataWidth];
            elem_b    = weights_i[i*DataWidth +: DataWidth];
            ext_a     = {{DataWidth{elem_a[DataWidth-1]}}, elem_a};
            ext_b     = {{DataWidth{elem_b[DataWidth-1]}}, elem_b};
            prod_d[i] = ext_a * ext_b;
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < int'(MaxWidth); i++) begin
            sum_d = sum_d + {{(AccWidth-ProdWidth){prod_q[i][ProdWidth-1]}}, prod_q[i]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prod_valid_q <= 1'b0;
            sum_valid_q  <= 1'b0;
        end else begin
            prod_valid_q <= valid_i;
            sum_valid_q  <= prod_valid_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (valid_i) begin
            prod_q <= prod_d;
        end
        if (prod_valid_q) begin
            sum_q <= sum_d;
        end
    end

    assign prod_valid_o = prod_valid_q;
    assign sum_valid_o  = sum_valid_q;
    assign sum_o        = sum_q;

endmodule

// File: rtl/vector_mac.sv
// Job-level control for the vector MAC: weight register, vector count, FSM and accumulator.
module vector_mac
    import vector_mac_pkg::*;
#(
    parameter int unsigned DataWidth = DefDataWidth,
    parameter int unsigned MaxWidth  = DefMaxWidth,
    parameter int unsigned AccWidth  = DefAccWidth
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          weightLoad,
    input  logic [MaxWidth*DataWidth-1:0] weightIn,
    input  logic                          start,
    input  logic [CountWidth-1:0]         numVecs,
    input  logic                          vecValid,
    input  logic [MaxWidth*DataWidth-1:0] vecIn,
    output logic                          busy,
    output logic                          resultValid,
    output logic [AccWidth-1:0]           result
);

    localparam int unsigned VecWidth = MaxWidth * DataWidth;

    mac_state_e            state_q;
    logic [CountWidth-1:0] count_q;
    logic [VecWidth-1:0]   weights_q;
    logic [VecWidth-1:0]   vec_q;
    logic                  vec_valid_q;
    logic [AccWidth-1:0]   acc_q, acc_d;
    logic                  busy_q, result_valid_q;
    logic                  prod_valid, sum_valid;
    logic [AccWidth-1:0]   sum;
    logic                  accept;
    logic                  drain_done;

    assign accept = (state_q == StAccum) && vecValid;
    assign acc_d  = acc_q + sum;

    // No new vectors enter while draining, so the final sum is the one with nothing behind it.
    assign drain_done = sum_valid && !prod_valid && !vec_valid_q;

    dot_tree #(
        .DataWidth(DataWidth),
        .MaxWidth (MaxWidth),
        .AccWidth (AccWidth)
    ) u_dot_tree (
        .clk_i       (clk),
        .rst_i       (rst),
        .valid_i     (vec_valid_q),
        .vec_i       (vec_q),
        .weights_i   (weights_q),
        .prod_valid_o(prod_valid),
        .sum_valid_o (sum_valid),
        .sum_o       (sum)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            vec_q <= vecIn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            count_q        <= '0;
            weights_q      <= '0;
            vec_valid_q    <= 1'b0;
            acc_q          <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            vec_valid_q    <= 1'b0;
            result_valid_q <= 1'b0;
            if (sum_valid) begin
                acc_q <= acc_d;
            end
            unique case (state_q)
                StIdle: begin
                    if (weightLoad) begin
                        weights_q <= weightIn;
                    end
                    if (start) begin
                        acc_q <= '0;
                        if (numVecs == '0) begin
                            state_q        <= StDone;
                            result_valid_q <= 1'b1;
                        end else begin
                            count_q <= numVecs;
                            state_q <= StAccum;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                StAccum: begin
                    if (vecValid) begin
                        vec_valid_q <= 1'b1;
                        count_q     <= count_q - CountWidth'(1);
                        if (count_q == CountWidth'(1)) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (drain_done) begin
                        state_q        <= StDone;
                        busy_q         <= 1'b0;
                        result_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign resultValid = result_valid_q;
    assign result      = acc_q;

endmodule

// File: tb/tb_vector_mac.sv
// Randomised scoreboard bench for vector_mac with a plain-arithmetic dot-product model.
module tb_vector_mac;

    localparam int DW = 8;
    localparam int MW = 9;
    localparam int AW = 32;
    localparam int VW = MW * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          weightLoad;
    logic [VW-1:0] weightIn;
    logic          start;
    logic [7:0]    numVecs;
    logic          vecValid;
    logic [VW-1:0] vecIn;
    logic          busy;
    logic          resultValid;
    logic [AW-1:0] result;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            pulses   = 0;
    int            exp_q[$];
    logic [VW-1:0] vecs[$];
    logic [VW-1:0] wm;

    vector_mac dut (
        .clk        (clk),
        .rst        (rst),
        .weightLoad (weightLoad),
        .weightIn   (weightIn),
        .start      (start),
        .numVecs    (numVecs),
        .vecValid   (vecValid),
        .vecIn      (vecIn),
        .busy       (busy),
        .resultValid(resultValid),
        .result     (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int dot(input logic [VW-1:0] v, input logic [VW-1:0] w);
        int s = 0;
        for (int i = 0; i < MW; i++) begin
            s += int'($signed(v[i*DW +: DW])) * int'($signed(w[i*DW +: DW]));
        end
        return s;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] r;
        for (int i = 0; i < MW; i++) r[i*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    // Monitor: every result pulse must match the oldest outstanding job.
    always @(negedge clk) begin
        if (resultValid === 1'b1) begin
            pulses++;
            check("busy_at_done", {63'b0, busy}, 0);
            if (exp_q.size() == 0) check("unexpected_result_pulse", 1, 0);
            else check("result", $signed(result), exp_q.pop_front());
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(input int old);
        for (int k = 0; k < 60 && pulses <= old; k++) begin
            vecValid = 1'($urandom);
            vecIn    = rand_vec();
            cycle();
        end
        vecValid = 1'b0;
        check("job_completed", {63'b0, pulses > old}, 1);
    endtask

    task automatic load_weights(input logic [VW-1:0] w);
        weightLoad = 1'b1;
        weightIn   = w;
        wm         = w;
        cycle();
        weightLoad = 1'b0;
    endtask

    task automatic run_job(input bit with_load, input logic [VW-1:0] new_w, input int bubble_pct);
        int e = 0;
        int old = pulses;
        if (with_load) wm = new_w;
        foreach (vecs[k]) e += dot(vecs[k], wm);
        exp_q.push_back(e);
        start      = 1'b1;
        numVecs    = 8'(vecs.size());
        weightLoad = with_load;
        weightIn   = new_w;
        cycle();
        start      = 1'b0;
        weightLoad = 1'b0;
        if (vecs.size() > 0) check("busy_in_accum", {63'b0, busy}, 1);
        foreach (vecs[k]) begin
            for (int b = 0; b < 3 && int'($urandom_range(99)) < bubble_pct; b++) begin
                vecValid = 1'b0;
                vecIn    = rand_vec();
                cycle();
            end
            vecValid = 1'b1;
            vecIn    = vecs[k];
            cycle();
        end
        vecValid = 1'b0;
        wait_pulse(old);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int old;
        int lat;
        logic [VW-1:0] w1, w2, v1, v2;

        rst = 1'b1; weightLoad = 1'b0; weightIn = '0; start = 1'b0;
        numVecs = '0; vecValid = 1'b0; vecIn = '0; wm = '0;
        repeat (3) cycle();
        check("reset_busy", {63'b0, busy}, 0);
        check("reset_valid", {63'b0, resultValid}, 0);
        check("reset_result", $signed(result), 0);
        rst = 1'b0;
        cycle();

        // Weights all 1, one vector of 2s: 18 in the fourth cycle after acceptance.
        load_weights({MW{8'h01}});
        exp_q.push_back(18);
        old = pulses;
        start = 1'b1; numVecs = 8'd1;
        cycle();
        start = 1'b0; vecValid = 1'b1; vecIn = {MW{8'h02}};
        cycle();
        vecValid = 1'b0;
        lat = 1;
        while (resultValid !== 1'b1 && lat < 20) begin
            cycle();
            lat++;
        end
        check("latency", lat, 4);
        wait_pulse(old);

        // Single negative weight, three -128 vectors with a bubble.
        load_weights({{(MW-1){8'h00}}, 8'h80});
        vecs.delete();
        repeat (3) vecs.push_back({{(MW-1){8'h00}}, 8'h80});
        run_job(1'b0, '0, 60);
        check("neg_square_model", exp_q.size(), 0);

        // Zero-length job.
        exp_q.push_back(0);
        old = pulses;
        start = 1'b1; numVecs = 8'd0;
        cycle();
        start = 1'b0;
        check("zero_job_valid", {63'b0, resultValid}, 1);
        check("zero_job_busy", {63'b0, busy}, 0);
        check("zero_job_result", $signed(result), 0);
        cycle();
        check("zero_job_busy_after", {63'b0, busy}, 0);
        check("zero_job_single_pulse", {63'b0, resultValid}, 0);
        wait_pulse(old);

        // Reset mid-job with a product in flight.
        load_weights({MW{8'h05}});
        start = 1'b1; numVecs = 8'd2;
        cycle();
        start = 1'b0; vecValid = 1'b1; vecIn = {MW{8'h03}};
        cycle();
        vecValid = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        wm = '0;
        for (int k = 0; k < 8; k++) begin
            vecValid = 1'($urandom);
            vecIn    = rand_vec();
            cycle();
        end
        vecValid = 1'b0;
        check("abort_busy", {63'b0, busy}, 0);
        check("abort_valid", {63'b0, resultValid}, 0);
        check("abort_result", $signed(result), 0);
        vecs.delete();
        vecs.push_back(rand_vec());
        run_job(1'b0, '0, 0);

        // Vector with start is dropped; start/weightLoad during ACCUM are ignored.
        w1 = rand_vec(); w2 = ~w1; v1 = rand_vec(); v2 = rand_vec();
        load_weights(w1);
        exp_q.push_back(dot(v1, w1) + dot(v2, w1));
        old = pulses;
        start = 1'b1; numVecs = 8'd2; vecValid = 1'b1; vecIn = rand_vec();
        cycle();
        start = 1'b0; vecValid = 1'b0;
        weightLoad = 1'b1; weightIn = w2; start = 1'b1; numVecs = 8'd5;
        cycle();
        weightLoad = 1'b0; start = 1'b0;
        vecValid = 1'b1; vecIn = v1;
        cycle();
        vecIn = v2;
        cycle();
        vecValid = 1'b0;
        wait_pulse(old);

        // Worst-case magnitude over a maximum-length job.
        vecs.delete();
        repeat (255) vecs.push_back({MW{8'h80}});
        run_job(1'b1, {MW{8'h80}}, 0);
        check("max_job_model", dot({MW{8'h80}}, wm) * 255, 37601280);

        // Random jobs, some loading weights on the start cycle.
        for (int j = 0; j < 24; j++) begin
            vecs.delete();
            repeat ($urandom_range(0, 6)) vecs.push_back(rand_vec());
            run_job(1'($urandom), rand_vec(), 30);
        end

        repeat (5) cycle();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
